// File: rtl/life_gen_ctrl.sv
// Generation sequencer for the Game-of-Life grid register.
// Paces updates, counts generations, flags still-life/extinction.
module life_gen_ctrl #(
  parameter int N     = 16,
  parameter int PER_W = 24,
  parameter int GEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             run,
  input  logic             step,
  input  logic             halt_en,
  input  logic [PER_W-1:0] period,
  input  logic [N*N-1:0]   cur_grid,
  input  logic [N*N-1:0]   next_grid,
  output logic             grid_en,
  output logic             grid_sel,
  output logic [GEN_W-1:0] gen_count,
  output logic             stable,
  output logic             extinct,
  output logic             halted
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    STEP,
    HALT
  } state_t;

  state_t state, state_n;

  logic [PER_W-1:0] tick, tick_n, last;
  logic [GEN_W-1:0] gen_n;
  logic             en_n, sel_n;
  logic             stable_n, extinct_n;
  logic             upd, same, dead, hcond;

  assign last  = (period == '0) ? '0
               : period - PER_W'(1);
  assign upd   = grid_en & ~grid_sel;
  assign same  = (next_grid == cur_grid);
  assign dead  = (next_grid == '0);
  assign hcond = upd & halt_en & (same | dead);

  always_comb begin
    state_n   = state;
    tick_n    = tick;
    en_n      = 1'b0;
    sel_n     = 1'b0;
    gen_n     = gen_count;
    stable_n  = stable;
    extinct_n = extinct;
    // An in-flight update always retires on this edge unless load wins.
    if (upd) begin
      if (gen_count != '1)
        gen_n = gen_count + GEN_W'(1);
      stable_n  = same;
      extinct_n = dead;
    end
    if (load) begin
      state_n   = LOAD;
      tick_n    = '0;
      en_n      = 1'b1;
      sel_n     = 1'b1;
      gen_n     = '0;
      stable_n  = 1'b0;
      extinct_n = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (run) begin
            state_n = RUN;
            tick_n  = '0;
          end else if (step) begin
            state_n = STEP;
            en_n    = 1'b1;
          end
        end
        LOAD: begin
          state_n = run ? RUN : IDLE;
          tick_n  = '0;
        end
        STEP: begin
          state_n = hcond ? HALT : IDLE;
        end
        RUN: begin
          if (hcond) begin
            state_n = HALT;
            tick_n  = '0;
          end else if (!run) begin
            state_n = IDLE;
            tick_n  = '0;
          end else if (tick >= last) begin
            en_n   = 1'b1;
            tick_n = '0;
          end else begin
            tick_n = tick + PER_W'(1);
          end
        end
        HALT: begin
          state_n = HALT;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      tick      <= '0;
      grid_en   <= 1'b0;
      grid_sel  <= 1'b0;
      gen_count <= '0;
      stable    <= 1'b0;
      extinct   <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state     <= state_n;
      tick      <= tick_n;
      grid_en   <= en_n;
      grid_sel  <= sel_n;
      gen_count <= gen_n;
      stable    <= stable_n;
      extinct   <= extinct_n;
      halted    <= (state_n == HALT);
    end
  end

endmodule
